// File: rtl/multdiv_ctrl.sv
// Sequencer for a signed 32-bit multiply (radix-2 Booth) and divide (restoring)
// built around one shared external 32-bit adder; one adder operation per cycle.
module multdiv_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] add_x,
    output logic [31:0] add_y,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [2:0] {
        IDLE, MULT, DIV_PRE, DIV_ITER, DIV_POST, DONE
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;      // latched A
    logic [31:0] b_q, b_d;      // latched B, replaced by |B| during divide
    logic [31:0] hi_q, hi_d;    // Booth high word / divide remainder
    logic [31:0] lo_q, lo_d;    // Booth low word / divide quotient
    logic        q_q, q_d;      // Booth extra bit
    logic        neg_q, neg_d;  // quotient sign
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;

    logic        start;
    logic [31:0] r_sh;

    assign start = ctrl_MULT | ctrl_DIV;
    assign r_sh  = {hi_q[30:0], lo_q[31]};

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

    // Adder operand selection; the sum comes back combinationally the same cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (state_q)
            MULT: begin
                add_x = hi_q;
                case ({lo_q[0], q_q})
                    2'b01:   add_y = a_q;
                    2'b10: begin
                        add_y   = ~a_q;
                        add_cin = 1'b1;
                    end
                    default: add_y = '0;
                endcase
            end
            DIV_PRE: begin
                if (!cnt_q[0]) begin
                    add_x   = a_q[31] ? ~a_q : a_q;
                    add_cin = a_q[31];
                end else begin
                    add_x   = b_q[31] ? ~b_q : b_q;
                    add_cin = b_q[31];
                end
            end
            DIV_ITER: begin
                add_x   = r_sh;
                add_y   = ~b_q;
                add_cin = 1'b1;
            end
            DIV_POST: begin
                add_x   = neg_q ? ~lo_q : lo_q;
                add_cin = neg_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        q_d      = q_q;
        neg_d    = neg_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (start) begin
            // A start in any state aborts whatever was running.
            state_d  = ctrl_MULT ? MULT : DIV_PRE;
            cnt_d    = '0;
            a_d      = data_operandA;
            b_d      = data_operandB;
            hi_d     = '0;
            lo_d     = data_operandB;
            q_d      = 1'b0;
            result_d = '0;
            exc_d    = 1'b0;
        end else begin
            case (state_q)
                MULT: begin
                    // Bit 32 of the true signed sum keeps the arithmetic shift exact.
                    hi_d  = {add_x[31] ^ add_y[31] ^ add_cout, add_sum[31:1]};
                    lo_d  = {add_sum[0], lo_q[31:1]};
                    q_d   = lo_q[0];
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        rdy_d    = 1'b1;
                        result_d = lo_d;
                        exc_d    = (hi_d != {32{lo_d[31]}});
                    end
                end
                DIV_PRE: begin
                    if (!cnt_q[0]) begin
                        if (b_q == '0) begin
                            state_d  = DONE;
                            rdy_d    = 1'b1;
                            result_d = '0;
                            exc_d    = 1'b1;
                        end else begin
                            lo_d  = add_sum;
                            neg_d = a_q[31] ^ b_q[31];
                            cnt_d = 6'd1;
                        end
                    end else begin
                        b_d     = add_sum;
                        hi_d    = '0;
                        cnt_d   = '0;
                        state_d = DIV_ITER;
                    end
                end
                DIV_ITER: begin
                    hi_d  = add_cout ? add_sum : r_sh;
                    lo_d  = {lo_q[30:0], add_cout};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = DIV_POST;
                        cnt_d   = '0;
                    end
                end
                DIV_POST: begin
                    // A positive quotient of 2^31 only arises from MIN / -1.
                    state_d  = DONE;
                    rdy_d    = 1'b1;
                    result_d = add_sum;
                    exc_d    = ~neg_q & lo_q[31];
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            q_q      <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            q_q      <= q_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port ctrl_MULT, input, 1 bit: one-cycle start pulse for a signed multiply.
REQ-004 SHALL have port ctrl_DIV, input, 1 bit: one-cycle start pulse for a signed divide.
REQ-005 SHALL have port data_operandA, input, 32 bits: multiplicand or dividend, sampled only in the start cycle.
REQ-006 SHALL have port data_operandB, input, 32 bits: multiplier or divisor, sampled only in the start cycle.
REQ-007 SHALL have port add_x, output, 32 bits: first operand to the shared external 32-bit CLA adder.
REQ-008 SHALL have port add_y, output, 32 bits: second operand to the shared adder.
REQ-009 SHALL have port add_cin, output, 1 bit: carry-in to the shared adder.
REQ-010 SHALL have port add_sum, input, 32 bits: combinational sum of add_x + add_y + add_cin, valid in the same cycle.
REQ-011 SHALL have port add_cout, input, 1 bit: combinational carry-out of the shared adder.
REQ-012 SHALL have port data_result, output, 32 bits: product low word or quotient.
REQ-013 SHALL have port data_exception, output, 1 bit: overflow or divide-by-zero flag, qualified by data_resultRDY.
REQ-014 SHALL have port data_resultRDY, output, 1 bit: registered one-cycle completion pulse.

Function
REQ-015 SHALL use states IDLE, MULT, DIV_PRE, DIV_ITER, DIV_POST and DONE, with a 6-bit iteration counter.
REQ-016 SHALL latch operands and leave IDLE on any cycle where ctrl_MULT or ctrl_DIV is high; if both are high, MULT SHALL win.
REQ-017 SHALL treat a start during any non-IDLE state as abort-and-restart: relatch operands, reset the counter, and suppress data_resultRDY for the aborted operation.
REQ-018 SHALL drive add_x=0, add_y=0, add_cin=0 in IDLE and DONE.
REQ-019 MULT: radix-2 Booth over 32 iterations, one per cycle, on a 65-bit register {hi[31:0], lo[31:0], q}.
REQ-020 MULT register init: lo=B, hi=0, q=0.
REQ-021 MULT per-iteration adder drive: add_x=hi always; {lo[0],q}=01 -> add_y=A, add_cin=0; 10 -> add_y=~A, add_cin=1; 00 or 11 -> add_y=0, add_cin=0.
REQ-022 MULT register update: arithmetic right shift of {add_sum, lo, q} by 1, with the sign extended from the true 33-bit signed sum.
REQ-023 MULT result: data_result=lo; data_exception=1 iff hi is not all copies of lo[31].
REQ-024 MULT latency: data_resultRDY SHALL be high exactly 32 cycles after the start cycle.
REQ-025 DIV_PRE: 2 cycles using the adder: cycle 1 computes |A| via ~A+1 if A[31] (else passes A through); cycle 2 computes |B| the same way.
REQ-026 DIV_ITER: 32 restoring iterations; shift {R, Q} left by 1; add_x=R, add_y=~|B|, add_cin=1; if add_cout=1, R=add_sum and Q[0]=1; otherwise R is unchanged and Q[0]=0.
REQ-027 DIV_POST: 1 cycle; quotient negated via the adder iff A[31]^B[31]; quotient truncates toward zero; remainder is discarded.
REQ-028 DIV latency: data_resultRDY SHALL be high exactly 35 cycles after the start cycle.
REQ-029 Divide-by-zero (B=0): skip to DONE, data_result=0, data_exception=1, data_resultRDY high 1 cycle after the start cycle.
REQ-030 Divide overflow (A=0x80000000, B=0xFFFFFFFF): data_result=0x80000000, data_exception=1, normal 35-cycle latency.
REQ-031 data_result and data_exception SHALL hold their values from DONE until the next accepted start, then clear to 0 on the cycle after that start.
REQ-032 DONE SHALL last one cycle, then return to IDLE.

Reset
REQ-033 When reset is high at a clock edge: state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, and all adder outputs=0.
REQ-034 Reset SHALL take priority over ctrl_MULT and ctrl_DIV; an operation interrupted by reset SHALL never assert data_resultRDY.

Verification
REQ-035 MULT 7 x 0xFFFFFFFD (-3) -> data_result=0xFFFFFFEB, data_exception=0, data_resultRDY at start+32.
REQ-036 MULT 0x00010000 x 0x00010000 -> data_result=0x00000000, data_exception=1.
REQ-037 DIV 0xFFFFFF9C (-100) / 7 -> data_result=0xFFFFFFF2 (-14), data_exception=0, data_resultRDY at start+35.
REQ-038 DIV 5 / 0 -> data_result=0, data_exception=1, data_resultRDY at start+1.
REQ-039 DIV started, then ctrl_MULT 3 x 4 at start+10 -> no data_resultRDY for the DIV; data_result=12 at MULT start+32.
REQ-040 Reset asserted at start+15 of MULT -> all outputs 0, no data_resultRDY through start+40, add_x/add_y/add_cin=0.
